// File: rtl/uart_receive.sv
//============================================================================
// Module   : uart_receive
// Purpose  : 16x-oversampled 8N1 serial receiver with a processor-readable
//            receive buffer. Optional macro UART_RX_ERR_EN enables the
//            frame_err / overrun flags and discards bytes with a low stop bit.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module uart_receive (
   input  logic       clk,
   input  logic       rst,
   input  logic       brg_tick,
   input  logic       rxd,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   output logic [7:0] rx_data,
   output logic       rda,
   output logic       frame_err,
   output logic       overrun
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   localparam logic [3:0] c_MID_TICK  = 4'd7;
   localparam logic [3:0] c_LAST_TICK = 4'd15;
   localparam logic [2:0] c_LAST_BIT  = 3'd7;

   state_t     r_state;
   logic       r_rxd_meta;
   logic       r_rxd_s;
   logic [3:0] r_tcnt;
   logic [2:0] r_bcnt;
   logic [7:0] r_shreg;
   logic       w_rd_strobe;

`ifdef UART_RX_ERR_EN
   logic       r_frame_err;
   logic       r_overrun;
`endif

   assign w_rd_strobe = iocs & iorw & (ioaddr == 2'b00);

   // Both synchronizer flops reset high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rxd_meta <= 1'b1;
         r_rxd_s    <= 1'b1;
      end else begin
         r_rxd_meta <= rxd;
         r_rxd_s    <= r_rxd_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_tcnt      <= 4'd0;
         r_bcnt      <= 3'd0;
         r_shreg     <= 8'h00;
         rx_data     <= 8'h00;
         rda         <= 1'b0;
`ifdef UART_RX_ERR_EN
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`endif
      end else begin
         // Read clears come first so a same-cycle completion below wins.
         if (w_rd_strobe) begin
            rda         <= 1'b0;
`ifdef UART_RX_ERR_EN
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`endif
         end

         case (r_state)
            S_IDLE: begin
               if (!r_rxd_s) begin
                  r_tcnt  <= 4'd0;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (brg_tick) begin
                  r_tcnt <= r_tcnt + 4'd1;
                  if (r_tcnt == c_MID_TICK) begin
                     if (!r_rxd_s) begin
                        r_tcnt  <= 4'd0;
                        r_bcnt  <= 3'd0;
                        r_state <= S_DATA;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
               end
            end

            S_DATA: begin
               if (brg_tick) begin
                  r_tcnt <= r_tcnt + 4'd1;
                  if (r_tcnt == c_LAST_TICK) begin
                     r_shreg <= {r_rxd_s, r_shreg[7:1]};
                     r_bcnt  <= r_bcnt + 3'd1;
                     if (r_bcnt == c_LAST_BIT) begin
                        r_state <= S_STOP;
                     end
                  end
               end
            end

            S_STOP: begin
               if (brg_tick) begin
                  r_tcnt <= r_tcnt + 4'd1;
                  if (r_tcnt == c_LAST_TICK) begin
                     if (r_rxd_s) begin
                        rx_data <= r_shreg;
                        rda     <= 1'b1;
`ifdef UART_RX_ERR_EN
                        if (rda && !w_rd_strobe) begin
                           r_overrun <= 1'b1;
                        end
`endif
                        r_state <= S_IDLE;
                     end else begin
`ifdef UART_RX_ERR_EN
                        r_frame_err <= 1'b1;
`else
                        rx_data <= r_shreg;
                        rda     <= 1'b1;
`endif
                        r_state <= S_BREAK;
                     end
                  end
               end
            end

            // Hold here until the line returns high so a stuck-low RX pin
            // cannot keep retriggering frames.
            S_BREAK: begin
               if (r_rxd_s) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef UART_RX_ERR_EN
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
`else
   assign frame_err = 1'b0;
   assign overrun   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_receive.sv
// Directed self-checking bench for uart_receive; a scoreboard queue holds the
// bytes expected in rx_data, popped as each frame completes.
`default_nettype none

module tb_uart_receive;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       brg_tick = 1'b0;
   logic       rxd = 1'b1;
   logic       iocs = 1'b0;
   logic       iorw = 1'b0;
   logic [1:0] ioaddr = 2'b00;
   logic [7:0] rx_data;
   logic       rda;
   logic       frame_err;
   logic       overrun;

   int errors = 0;
   int checks = 0;
   int div = 0;
   logic [7:0] exp_q[$];

`ifdef UART_RX_ERR_EN
   localparam logic c_ERR_EN = 1'b1;
`else
   localparam logic c_ERR_EN = 1'b0;
`endif

   uart_receive dut (
      .clk      (clk),
      .rst      (rst),
      .brg_tick (brg_tick),
      .rxd      (rxd),
      .iocs     (iocs),
      .iorw     (iorw),
      .ioaddr   (ioaddr),
      .rx_data  (rx_data),
      .rda      (rda),
      .frame_err(frame_err),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   // 16x tick every 4 clocks: one bit = 64 clocks.
   always @(posedge clk) begin
      if (div == 3) begin
         div      <= 0;
         brg_tick <= 1'b1;
      end else begin
         div      <= div + 1;
         brg_tick <= 1'b0;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag);
      logic [7:0] exp;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, rx_data);
      end else begin
         exp = exp_q.pop_front();
         check(tag, rx_data, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         @(negedge clk);
         if (brg_tick) k++;
      end
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      wait_ticks(16);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic expect_byte);
      if (expect_byte) exp_q.push_back(d);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_bit);
   endtask

   task automatic bus_access(input logic rw, input logic [1:0] addr);
      @(negedge clk);
      iocs   = 1'b1;
      iorw   = rw;
      ioaddr = addr;
      @(negedge clk);
      iocs   = 1'b0;
      iorw   = 1'b0;
      ioaddr = 2'b00;
   endtask

   initial begin
      int bad_rda;
      int bad_data;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_rda", {7'd0, rda}, 8'd0);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_frame_err", {7'd0, frame_err}, 8'd0);
      check("reset_overrun", {7'd0, overrun}, 8'd0);

      // Idle line for 1000 cycles
      bad_rda = 0;
      bad_data = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rda !== 1'b0) bad_rda++;
         if (rx_data !== 8'h00) bad_data++;
      end
      check("idle_rda_count", bad_rda[7:0], 8'd0);
      check("idle_data_count", bad_data[7:0], 8'd0);

      // 8'hA5 with stop-sample timing window
      exp_q.push_back(8'hA5);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(bit'(8'hA5 >> i));
      rxd = 1'b1;
      wait_ticks(6);
      check("a5_rda_before_stop_sample", {7'd0, rda}, 8'd0);
      wait_ticks(5);
      check("a5_rda_after_stop_sample", {7'd0, rda}, 8'd1);
      wait_ticks(5);
      check_pop("a5_rx_data");

      bus_access(1'b0, 2'b00);
      check("write_addr0_no_effect", {7'd0, rda}, 8'd1);
      bus_access(1'b1, 2'b01);
      check("read_addr1_no_effect", {7'd0, rda}, 8'd1);
      bus_access(1'b1, 2'b00);
      check("read_clears_rda", {7'd0, rda}, 8'd0);
      check("read_keeps_rx_data", rx_data, 8'hA5);

      // Short low glitch must be rejected
      rxd = 1'b0;
      wait_ticks(4);
      rxd = 1'b1;
      wait_ticks(200);
      check("glitch_rda", {7'd0, rda}, 8'd0);
      check("glitch_rx_data", rx_data, 8'hA5);

      // Back-to-back frames, no read in between
      send_frame(8'h3C, 1'b1, 1'b1);
      check_pop("b2b_first_rx_data");
      check("b2b_first_overrun", {7'd0, overrun}, 8'd0);
      send_frame(8'hC3, 1'b1, 1'b1);
      check_pop("b2b_second_rx_data");
      check("b2b_second_rda", {7'd0, rda}, 8'd1);
      check("b2b_second_overrun", {7'd0, overrun}, {7'd0, c_ERR_EN});
      bus_access(1'b1, 2'b00);
      check("b2b_read_rda", {7'd0, rda}, 8'd0);
      check("b2b_read_overrun", {7'd0, overrun}, 8'd0);

      // Low stop bit, then line held low (must sit in BREAK)
      send_frame(8'h55, 1'b0, !c_ERR_EN);
      check("fe_frame_err", {7'd0, frame_err}, {7'd0, c_ERR_EN});
      check("fe_rda", {7'd0, rda}, {7'd0, !c_ERR_EN});
      if (c_ERR_EN) check("fe_rx_data_kept", rx_data, 8'hC3);
      else check_pop("fe_rx_data_loaded");
      bus_access(1'b1, 2'b00);
      wait_ticks(200);
      check("break_no_retrigger_rda", {7'd0, rda}, 8'd0);
      check("break_no_retrigger_fe", {7'd0, frame_err}, 8'd0);
      rxd = 1'b1;
      wait_ticks(32);
      send_frame(8'h5A, 1'b1, 1'b1);
      check_pop("after_break_rx_data");
      check("after_break_rda", {7'd0, rda}, 8'd1);
      bus_access(1'b1, 2'b00);

      // Reset during bit 4 of 8'hFF, then 8'h12
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rxd = 1'b1;
      wait_ticks(8);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midrst_rda", {7'd0, rda}, 8'd0);
      check("midrst_rx_data", rx_data, 8'h00);
      wait_ticks(200);
      check("midrst_no_partial", {7'd0, rda}, 8'd0);
      send_frame(8'h12, 1'b1, 1'b1);
      check_pop("midrst_rx_data_12");
      check("midrst_rda_12", {7'd0, rda}, 8'd1);

      check("scoreboard_empty", exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
